tour_logic: RTL and testbench

- Hardware knight's-tour solver for a 5x5 board.
- On a go pulse it runs a deterministic depth-first backtracking search from (x_start, y_start) until all 25 squares are visited, then asserts done.
- The resulting 24-move sequence is read back by index as one-hot move codes.
- Sits between the command/UART front end, which supplies the start square, and the tour-command sequencer, which reads moves via indx/move.

---
 rtl/tour_if.sv | 12 +
 rtl/tour_logic.sv | 198 +++++++++++++++++++
 tb/tb_tour_logic.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_if.sv
// Command and readback bundle between the front end, the tour solver and the sequencer.
interface tour_if;
    logic [2:0] x_start;
    logic [2:0] y_start;
    logic       go;
    logic       done;
    logic [4:0] indx;
    logic [7:0] move;

    modport master (output x_start, y_start, go, indx, input done, move);
    modport slave  (input x_start, y_start, go, indx, output done, move);
endinterface

// File: rtl/tour_logic.sv
// Knight's-tour solver for a 5x5 board: deterministic lowest-bit-first depth-first backtracking.
// The finished 24-move tour is read back by index as one-hot move codes.
module tour_logic (
    input  logic  clk,
    input  logic  rst_n,
    tour_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StInit, StPossible, StMakeMove, StBackup} state_e;

    state_e     state_q, state_d;
    logic [4:0] board [5][5];
    logic [7:0] last_move [24];
    logic [7:0] poss_moves [24];
    logic [2:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [4:0] move_num_q, move_num_d;
    logic [2:0] try_q, try_d;
    logic       done_q, done_d;

    logic       update_position;
    logic       board_we, board_clr, lm_we, pm_we;
    logic [2:0] wr_x, wr_y;
    logic [4:0] wr_val;
    logic [7:0] lm_val, poss, avail, prev_mv;
    logic [2:0] pick, prev_k;

    // Offsets are 3-bit two's complement so coordinates wrap and range-check cheaply.
    function automatic logic [2:0] dx_of(input logic [2:0] k);
        logic [2:0] d;
        case (k)
            3'd0, 3'd5: d = 3'b001;
            3'd1, 3'd4: d = 3'b111;
            3'd2, 3'd3: d = 3'b110;
            default:    d = 3'b010;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] dy_of(input logic [2:0] k);
        logic [2:0] d;
        case (k)
            3'd0, 3'd1: d = 3'b010;
            3'd2, 3'd7: d = 3'b001;
            3'd3, 3'd6: d = 3'b111;
            default:    d = 3'b110;
        endcase
        return d;
    endfunction

    function automatic logic in_range(input logic [2:0] c, input logic [2:0] d);
        logic [4:0] s;
        s = {2'b00, c} + {{2{d[2]}}, d};
        return s <= 5'd4;
    endfunction

    always_comb begin
        poss = '0;
        for (int k = 0; k < 8; k++) begin
            if (in_range(cur_x_q, dx_of(3'(k))) && in_range(cur_y_q, dy_of(3'(k)))) begin
                if (board[cur_x_q + dx_of(3'(k))][cur_y_q + dy_of(3'(k))] == 5'd0) poss[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cur_x_d         = cur_x_q;
        cur_y_d         = cur_y_q;
        move_num_d      = move_num_q;
        try_d           = try_q;
        done_d          = done_q;
        update_position = 1'b0;
        board_we        = 1'b0;
        board_clr       = 1'b0;
        lm_we           = 1'b0;
        pm_we           = 1'b0;
        lm_val          = '0;
        wr_x            = cur_x_q;
        wr_y            = cur_y_q;
        wr_val          = '0;
        avail           = '0;
        pick            = '0;
        prev_mv         = '0;
        prev_k          = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.go) begin
                    done_d  = 1'b0;
                    state_d = StInit;
                end
            end
            StInit: begin
                if (bus.x_start > 3'd4 || bus.y_start > 3'd4) begin
                    state_d = StIdle;
                end else begin
                    board_clr  = 1'b1;
                    board_we   = 1'b1;
                    wr_x       = bus.x_start;
                    wr_y       = bus.y_start;
                    wr_val     = 5'd1;
                    cur_x_d    = bus.x_start;
                    cur_y_d    = bus.y_start;
                    move_num_d = '0;
                    state_d    = StPossible;
                end
            end
            StPossible: begin
                pm_we   = 1'b1;
                try_d   = '0;
                state_d = StMakeMove;
            end
            StMakeMove: begin
                avail = poss_moves[move_num_q] & (8'hFF << try_q);
                for (int k = 7; k >= 0; k--) begin
                    if (avail[k]) pick = 3'(k);
                end
                if (avail != 8'h00) begin
                    lm_we           = 1'b1;
                    lm_val          = 8'b1 << pick;
                    cur_x_d         = cur_x_q + dx_of(pick);
                    cur_y_d         = cur_y_q + dy_of(pick);
                    board_we        = 1'b1;
                    update_position = 1'b1;
                    wr_x            = cur_x_d;
                    wr_y            = cur_y_d;
                    wr_val          = move_num_q + 5'd2;
                    move_num_d      = move_num_q + 5'd1;
                    if (move_num_q == 5'd23) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StPossible;
                    end
                end else begin
                    state_d = StBackup;
                end
            end
            StBackup: begin
                if (move_num_q == 5'd0) begin
                    state_d = StIdle;
                end else begin
                    prev_mv = last_move[move_num_q - 5'd1];
                    for (int k = 0; k < 8; k++) begin
                        if (prev_mv[k]) prev_k = 3'(k);
                    end
                    move_num_d      = move_num_q - 5'd1;
                    board_we        = 1'b1;
                    update_position = 1'b1;
                    cur_x_d         = cur_x_q - dx_of(prev_k);
                    cur_y_d         = cur_y_q - dy_of(prev_k);
                    // Exhausted all eight options at the parent level: keep unwinding.
                    if (prev_k == 3'd7) begin
                        state_d = StBackup;
                    end else begin
                        try_d   = prev_k + 3'd1;
                        state_d = StMakeMove;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
            move_num_q <= '0;
            try_q      <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) board[i][j] <= '0;
            end
            for (int i = 0; i < 24; i++) begin
                last_move[i]  <= '0;
                poss_moves[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            move_num_q <= move_num_d;
            try_q      <= try_d;
            done_q     <= done_d;
            if (board_clr) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 5; j++) board[i][j] <= '0;
                end
            end
            if (board_we) board[wr_x][wr_y] <= wr_val;
            if (lm_we) last_move[move_num_q] <= lm_val;
            if (pm_we) poss_moves[move_num_q] <= poss;
        end
    end

    assign bus.done = done_q;
    assign bus.move = (bus.indx < 5'd24) ? last_move[bus.indx] : 8'h00;
endmodule

// File: tb/tb_tour_logic.sv
// Scoreboard bench for tour_logic: a software backtracking model supplies expected outcomes,
// a negedge monitor checks search endings and move readbacks as the DUT presents them.
module tb_tour_logic;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tour_if bus ();
    tour_logic dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam int DX [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
    localparam int DY [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

    typedef struct packed {
        logic        found;
        logic [31:0] steps;
        logic [2:0]  sx;
        logic [2:0]  sy;
    } srch_t;

    typedef struct packed {
        logic [4:0] idx;
        logic [7:0] mv;
        logic       replay;
    } rd_t;

    srch_t srch_q[$];
    rd_t   rd_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    ends = 0;
    logic  rd_vld = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Iterative depth-first search; each placed or removed square counts as one step.
    task automatic model_run(input int sx, input int sy, output bit found, output int steps,
                             output logic [191:0] tour);
        int bd [5][5];
        int px [25];
        int py [25];
        int nxt [25];
        int d, k, tx, ty;
        bit moved, stop;
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) bd[i][j] = 0;
        bd[sx][sy] = 1;
        px[0] = sx; py[0] = sy; nxt[0] = 0;
        d = 0; steps = 0; found = 1'b0; stop = 1'b0; tour = '0;
        while (!found && !stop) begin
            if (d == 24) begin
                found = 1'b1;
            end else begin
                moved = 1'b0;
                while (!moved && nxt[d] < 8) begin
                    k = nxt[d];
                    nxt[d]++;
                    tx = px[d] + DX[k];
                    ty = py[d] + DY[k];
                    if (tx >= 0 && tx < 5 && ty >= 0 && ty < 5) begin
                        if (bd[tx][ty] == 0) begin
                            bd[tx][ty] = d + 2;
                            tour[d*8 +: 8] = 8'(1 << k);
                            d++;
                            px[d] = tx; py[d] = ty; nxt[d] = 0;
                            steps++;
                            moved = 1'b1;
                        end
                    end
                end
                if (!moved) begin
                    if (d == 0) begin
                        stop = 1'b1;
                    end else begin
                        bd[px[d]][py[d]] = 0;
                        d--;
                        steps++;
                    end
                end
            end
        end
    endtask

    // Monitor: pops a search expectation when the solver returns to idle, a read expectation
    // whenever a readback is presented.
    initial begin
        int    pulses, rx, ry, nx, ny, k;
        bit    active;
        bit    vis [5][5];
        int    hist [26];
        srch_t e;
        rd_t   r;
        pulses = 0; active = 1'b0; rx = 0; ry = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
                pulses = 0;
            end else begin
                if (dut.update_position) pulses++;
                if (int'(dut.state_q) != 0) begin
                    active = 1'b1;
                end else if (active) begin
                    active = 1'b0;
                    ends++;
                    if (srch_q.size() == 0) begin
                        check("unexpected_search_end", 32'd1, 32'd0);
                    end else begin
                        e = srch_q.pop_front();
                        check("done_at_end", 32'(bus.done), 32'(e.found));
                        check("update_position_pulses", pulses, e.steps);
                        if (e.found) begin
                            for (int v = 0; v < 26; v++) hist[v] = 0;
                            for (int i = 0; i < 5; i++) begin
                                for (int j = 0; j < 5; j++) begin
                                    hist[dut.board[i][j]]++;
                                    vis[i][j] = 1'b0;
                                end
                            end
                            check("board_start_is_1", 32'(dut.board[e.sx][e.sy]), 32'd1);
                            for (int v = 1; v < 26; v++) check("board_value_once", hist[v], 1);
                            rx = int'(e.sx); ry = int'(e.sy);
                            vis[rx][ry] = 1'b1;
                        end
                    end
                    pulses = 0;
                end
                if (rd_vld) begin
                    if (rd_q.size() == 0) begin
                        check("unexpected_read", 32'd1, 32'd0);
                    end else begin
                        r = rd_q.pop_front();
                        check("move", 32'(bus.move), 32'(r.mv));
                        if (r.replay) begin
                            check("move_one_hot", 32'($onehot(bus.move)), 32'd1);
                            k = -1;
                            for (int b = 0; b < 8; b++) if (bus.move[b]) k = b;
                            if (k >= 0) begin
                                nx = rx + DX[k];
                                ny = ry + DY[k];
                                check("replay_in_board",
                                      32'(nx >= 0 && nx < 5 && ny >= 0 && ny < 5), 32'd1);
                                if (nx >= 0 && nx < 5 && ny >= 0 && ny < 5) begin
                                    check("replay_landing", 32'(dut.board[nx][ny]),
                                          32'(r.idx) + 32'd2);
                                    check("replay_no_revisit", 32'(vis[nx][ny]), 32'd0);
                                    vis[nx][ny] = 1'b1;
                                    rx = nx; ry = ny;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic pulse_go();
        @(posedge clk); #1;
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
    endtask

    task automatic run_search(input int sx, input int sy, input bit readback);
        bit           f;
        int           st, budget, start_ends, n;
        logic [191:0] t;
        srch_t        e;
        rd_t          r;
        f = 1'b0; st = 0; t = '0;
        if (sx <= 4 && sy <= 4) model_run(sx, sy, f, st, t);
        budget = (sx <= 4 && sy <= 4) ? 4 * st + 100 : 3;
        e.found = f; e.steps = st; e.sx = 3'(sx); e.sy = 3'(sy);
        srch_q.push_back(e);
        bus.x_start = 3'(sx);
        bus.y_start = 3'(sy);
        start_ends = ends;
        pulse_go();
        n = 0;
        while (ends == start_ends && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_chk++;
        if (ends != start_ends) begin
            n_pass++;
        end else begin
            $display("FAIL search_end (%0d,%0d): none after %0d cycles, want within %0d",
                     sx, sy, n, budget);
            #1 rst_n = 1'b0;
            srch_q.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        if (f && readback && ends != start_ends) begin
            for (int i = 0; i < 24; i++) begin
                @(posedge clk); #1;
                bus.indx = 5'(i);
                rd_vld = 1'b1;
                r.idx = 5'(i); r.mv = t[i*8 +: 8]; r.replay = 1'b1;
                rd_q.push_back(r);
            end
            @(posedge clk); #1;
            rd_vld = 1'b0;
            check("done_held_after_readback", 32'(bus.done), 32'd1);
        end
    endtask

    initial begin
        bit           f;
        int           st, nz;
        logic [191:0] t;
        rd_t          r;
        bus.go = 1'b0; bus.x_start = '0; bus.y_start = '0; bus.indx = '0;
        repeat (3) @(posedge clk); #1;
        nz = 0;
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) if (dut.board[i][j] != 0) nz++;
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_idle", 32'(int'(dut.state_q)), 32'd0);
        check("reset_move", 32'(bus.move), 32'd0);
        check("reset_board_nonzero", nz, 0);
        rst_n = 1'b1;

        run_search(2, 2, 1'b1);
        run_search(0, 0, 1'b1);
        run_search(0, 1, 1'b0);
        run_search(5, 0, 1'b0);

        for (int i = 24; i < 32; i++) begin
            @(posedge clk); #1;
            bus.indx = 5'(i);
            rd_vld = 1'b1;
            r.idx = 5'(i); r.mv = 8'h00; r.replay = 1'b0;
            rd_q.push_back(r);
        end
        @(posedge clk); #1;
        rd_vld = 1'b0;
        bus.indx = '0;

        // Abort well before the fastest possible completion, then rerun the same start.
        model_run(2, 2, f, st, t);
        bus.x_start = 3'd2; bus.y_start = 3'd2;
        pulse_go();
        repeat (st / 2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_reset_done", 32'(bus.done), 32'd0);
        check("mid_reset_idle", 32'(int'(dut.state_q)), 32'd0);
        check("mid_reset_board", 32'(dut.board[2][2]), 32'd0);
        check("mid_reset_move", 32'(bus.move), 32'd0);
        repeat (3) @(posedge clk);
        check("mid_reset_done_held_low", 32'(bus.done), 32'd0);
        #1 rst_n = 1'b1;
        run_search(2, 2, 1'b1);

        repeat (3) @(posedge clk);
        check("queues_drained", 32'(srch_q.size() + rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
